// File: rtl/jackpot_pkg.sv
// Shared state encoding, LED patterns and BCD helper for the jackpot game controller.
package jackpot_pkg;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        WIN      = 2'd1,
        RESTART  = 2'd2,
        GAMEOVER = 2'd3
    } state_t;

    localparam logic [3:0] ALL_ON       = 4'b1111;
    localparam logic [3:0] ALL_OFF      = 4'b0000;
    localparam logic [3:0] GAMEOVER_PAT = 4'b1010;

    // Converts a 0..99 integer into two packed BCD digits.
    function automatic logic [7:0] to_bcd2(input int unsigned value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that increments on enable and saturates at 99.
module bcd2_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= 8'h00;
        end else if (inc && value != 8'h99) begin
            if (value[3:0] == 4'd9) begin
                value[3:0] <= 4'd0;
                value[7:4] <= value[7:4] + 4'd1;
            end else begin
                value[3:0] <= value[3:0] + 4'd1;
            end
        end
    end

endmodule

// File: rtl/jackpot_scoreboard.sv
// Game controller: detects all-LEDs-lit jackpots, counts wins and tries in BCD,
// blinks a celebration, then requests a restart or locks into game over.
module jackpot_scoreboard
    import jackpot_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int TARGET      = 5
) (
    input  logic       out_clk,
    input  logic       reset,
    input  logic [3:0] leds,
    input  logic       press,
    output logic [3:0] led_out,
    output logic       win_pulse,
    output logic       restart,
    output logic       game_over,
    output logic [7:0] score_bcd,
    output logic [7:0] tries_bcd
);

    localparam int         HW         = $clog2(HOLD_CYCLES + 1);
    localparam logic [7:0] TARGET_BCD = to_bcd2(TARGET);

    state_t          state, state_next;
    logic [HW-1:0]   hold, hold_next;
    logic [3:0]      led_next;
    logic            win_next, restart_next, game_over_next;
    logic            jackpot, score_inc, tries_inc;

    assign jackpot   = (state == PLAY) && (leds == ALL_ON);
    assign score_inc = jackpot;
    assign tries_inc = (state == PLAY) && press;

    always_ff @(posedge out_clk) begin
        if (reset) begin
            state     <= PLAY;
            hold      <= '0;
            led_out   <= ALL_OFF;
            win_pulse <= 1'b0;
            restart   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_next;
            hold      <= hold_next;
            led_out   <= led_next;
            win_pulse <= win_next;
            restart   <= restart_next;
            game_over <= game_over_next;
        end
    end

    // Score is already updated when WIN is entered, so the target test at the end of the hold sees the new value.
    always_comb begin
        state_next     = state;
        hold_next      = hold;
        led_next       = led_out;
        win_next       = 1'b0;
        restart_next   = 1'b0;
        game_over_next = game_over;
        case (state)
            PLAY: begin
                led_next = leds;
                if (jackpot) begin
                    state_next = WIN;
                    win_next   = 1'b1;
                    hold_next  = HW'(HOLD_CYCLES - 1);
                    led_next   = ALL_ON;
                end
            end
            WIN: begin
                if (hold != '0) begin
                    hold_next = hold - HW'(1);
                    led_next  = ~led_out;
                end else if (score_bcd == TARGET_BCD) begin
                    state_next     = GAMEOVER;
                    led_next       = GAMEOVER_PAT;
                    game_over_next = 1'b1;
                end else begin
                    state_next   = RESTART;
                    restart_next = 1'b1;
                    led_next     = ALL_OFF;
                end
            end
            RESTART: begin
                state_next = PLAY;
            end
            GAMEOVER: begin
                led_next = GAMEOVER_PAT;
            end
            default: begin
                state_next = PLAY;
            end
        endcase
    end

    bcd2_counter score_counter (
        .clk   (out_clk),
        .reset (reset),
        .inc   (score_inc),
        .value (score_bcd)
    );

    bcd2_counter tries_counter (
        .clk   (out_clk),
        .reset (reset),
        .inc   (tries_inc),
        .value (tries_bcd)
    );

endmodule
